// File: rtl/fetch_mmu.sv
// Instruction-fetch MMU: bare/translated modes, fully-associative TLB, single-level page-table walker.
// Optional hit/miss performance counters are built only when FETCH_MMU_PERF_EN is defined.
module fetch_mmu #(
    parameter int unsigned VIRTUAL_ADDRESS_SIZE  = 64,
    parameter int unsigned PHYSICAL_ADDRESS_SIZE = 56,
    parameter int unsigned PAGE_OFFSET_BITS      = 12,
    parameter int unsigned VPN_BITS              = 20,
    parameter int unsigned TLB_ENTRIES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             doInstructionFetch,
    input  logic [VIRTUAL_ADDRESS_SIZE-1:0]  instructionAddress,
    input  logic                             translationEnable,
    input  logic [PHYSICAL_ADDRESS_SIZE-1:0] pageTableBase,
    input  logic                             flushTlb,
    output logic [PHYSICAL_ADDRESS_SIZE-1:0] translatedAddress,
    output logic                             doneTranslation,
    output logic                             translationFault,
    output logic                             busy,
    output logic                             doPtwFetch,
    output logic [PHYSICAL_ADDRESS_SIZE-1:0] ptwAddress,
    input  logic [63:0]                      ptwData,
    input  logic                             donePtwFetch,
    output logic [31:0]                      tlbHitCount,
    output logic [31:0]                      tlbMissCount
);

    localparam int unsigned PPN_BITS = PHYSICAL_ADDRESS_SIZE - PAGE_OFFSET_BITS;
    localparam int unsigned IDX_BITS = $clog2(TLB_ENTRIES);
    localparam int unsigned TAG_LSB  = PAGE_OFFSET_BITS + VPN_BITS;

    typedef enum logic [1:0] {IDLE, WALK, RESPOND} state_t;

    state_t                        state;
    logic [TLB_ENTRIES-1:0]        tlb_valid;
    logic [VPN_BITS-1:0]           tlb_vpn [TLB_ENTRIES];
    logic [PPN_BITS-1:0]           tlb_ppn [TLB_ENTRIES];
    logic [IDX_BITS-1:0]           rr_ptr;
    logic [VPN_BITS-1:0]           walk_vpn;
    logic [PAGE_OFFSET_BITS-1:0]   walk_off;
    logic                          flush_seen;

    logic [VPN_BITS-1:0]           req_vpn_c;
    logic [PAGE_OFFSET_BITS-1:0]   req_off_c;
    logic                          out_of_range_c;
    logic                          lookup_hit_c;
    logic [PPN_BITS-1:0]           hit_ppn_c;
    logic                          free_found_c;
    logic [IDX_BITS-1:0]           free_idx_c;
    logic [IDX_BITS-1:0]           victim_c;
    logic                          pte_ok_c;
    logic [PPN_BITS-1:0]           pte_ppn_c;
    logic                          hit_event_c;
    logic                          miss_event_c;
    logic                          install_c;
    logic                          unused_pte_bits;

    assign req_vpn_c      = instructionAddress[TAG_LSB-1:PAGE_OFFSET_BITS];
    assign req_off_c      = instructionAddress[PAGE_OFFSET_BITS-1:0];
    assign out_of_range_c = |(instructionAddress >> TAG_LSB);

    // PTE: bit0 valid, bit3 executable; remaining non-PPN bits are ignored
    assign pte_ok_c        = ptwData[0] & ptwData[3];
    assign pte_ppn_c       = ptwData[PHYSICAL_ADDRESS_SIZE-1:PAGE_OFFSET_BITS];
    assign unused_pte_bits = ^{ptwData[63:PHYSICAL_ADDRESS_SIZE], ptwData[2:1],
                               ptwData[PAGE_OFFSET_BITS-1:4]};

    // Associative lookup and victim choice (lowest free slot, else round-robin)
    always_comb begin
        lookup_hit_c = 1'b0;
        hit_ppn_c    = '0;
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (!lookup_hit_c && tlb_valid[i] && (tlb_vpn[i] == req_vpn_c)) begin
                lookup_hit_c = 1'b1;
                hit_ppn_c    = tlb_ppn[i];
            end
            if (!free_found_c && !tlb_valid[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_BITS'(i);
            end
        end
        victim_c = free_found_c ? free_idx_c : rr_ptr;
    end

    // A flush in the request cycle masks the lookup, turning a hit into a walk
    assign hit_event_c  = (state == IDLE) && doInstructionFetch && translationEnable &&
                          !out_of_range_c && lookup_hit_c && !flushTlb;
    assign miss_event_c = (state == IDLE) && doInstructionFetch && translationEnable &&
                          !out_of_range_c && !(lookup_hit_c && !flushTlb);
    assign install_c    = (state == WALK) && donePtwFetch && pte_ok_c &&
                          !flush_seen && !flushTlb;

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            busy              <= 1'b0;
            doneTranslation   <= 1'b0;
            translationFault  <= 1'b0;
            doPtwFetch        <= 1'b0;
            translatedAddress <= '0;
            ptwAddress        <= '0;
            tlb_valid         <= '0;
            rr_ptr            <= '0;
            walk_vpn          <= '0;
            walk_off          <= '0;
            flush_seen        <= 1'b0;
        end else begin
            doneTranslation  <= 1'b0;
            translationFault <= 1'b0;
            if (flushTlb) begin
                tlb_valid <= '0;
            end
            case (state)
                IDLE: begin
                    if (doInstructionFetch) begin
                        if (!translationEnable) begin
                            doneTranslation   <= 1'b1;
                            translatedAddress <= instructionAddress[PHYSICAL_ADDRESS_SIZE-1:0];
                        end else if (out_of_range_c) begin
                            doneTranslation   <= 1'b1;
                            translationFault  <= 1'b1;
                            translatedAddress <= '0;
                        end else if (hit_event_c) begin
                            doneTranslation   <= 1'b1;
                            translatedAddress <= {hit_ppn_c, req_off_c};
                        end else if (miss_event_c) begin
                            state      <= WALK;
                            busy       <= 1'b1;
                            doPtwFetch <= 1'b1;
                            ptwAddress <= pageTableBase + (PHYSICAL_ADDRESS_SIZE'(req_vpn_c) << 3);
                            walk_vpn   <= req_vpn_c;
                            walk_off   <= req_off_c;
                            flush_seen <= 1'b0;
                        end
                    end
                end
                WALK: begin
                    if (flushTlb) begin
                        flush_seen <= 1'b1;
                    end
                    if (donePtwFetch) begin
                        doPtwFetch      <= 1'b0;
                        doneTranslation <= 1'b1;
                        state           <= RESPOND;
                        if (pte_ok_c) begin
                            translatedAddress <= {pte_ppn_c, walk_off};
                        end else begin
                            translationFault  <= 1'b1;
                            translatedAddress <= '0;
                        end
                        if (install_c) begin
                            tlb_valid[victim_c] <= 1'b1;
                            if (!free_found_c) begin
                                rr_ptr <= rr_ptr + IDX_BITS'(1);
                            end
                        end
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // TLB tag/data storage; qualified by tlb_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (install_c) begin
            tlb_vpn[victim_c] <= walk_vpn;
            tlb_ppn[victim_c] <= pte_ppn_c;
        end
    end

`ifdef FETCH_MMU_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tlbHitCount  <= '0;
            tlbMissCount <= '0;
        end else begin
            if (hit_event_c) begin
                tlbHitCount <= tlbHitCount + 32'd1;
            end
            if (miss_event_c) begin
                tlbMissCount <= tlbMissCount + 32'd1;
            end
        end
    end
`else
    assign tlbHitCount  = '0;
    assign tlbMissCount = '0;
`endif

endmodule

// File: tb/tb_fetch_mmu.sv
// Self-checking bench for fetch_mmu: scoreboard of expected results plus a page-table responder model.
module tb_fetch_mmu;

    typedef struct {
        logic        fault;
        logic [55:0] pa;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        doInstructionFetch;
    logic [63:0] instructionAddress;
    logic        translationEnable;
    logic [55:0] pageTableBase;
    logic        flushTlb;
    logic [55:0] translatedAddress;
    logic        doneTranslation;
    logic        translationFault;
    logic        busy;
    logic        doPtwFetch;
    logic [55:0] ptwAddress;
    logic [63:0] ptwData;
    logic        donePtwFetch;
    logic [31:0] tlbHitCount;
    logic [31:0] tlbMissCount;

    exp_t        sb[$];
    logic [63:0] pte_mem [logic [55:0]];
    int          n_cmp;
    int          n_bad;
    int          walks;
    logic [55:0] last_ptw;
    logic        resp_enable;

    fetch_mmu dut (
        .clk                (clk),
        .reset              (reset),
        .doInstructionFetch (doInstructionFetch),
        .instructionAddress (instructionAddress),
        .translationEnable  (translationEnable),
        .pageTableBase      (pageTableBase),
        .flushTlb           (flushTlb),
        .translatedAddress  (translatedAddress),
        .doneTranslation    (doneTranslation),
        .translationFault   (translationFault),
        .busy               (busy),
        .doPtwFetch         (doPtwFetch),
        .ptwAddress         (ptwAddress),
        .ptwData            (ptwData),
        .donePtwFetch       (donePtwFetch),
        .tlbHitCount        (tlbHitCount),
        .tlbMissCount       (tlbMissCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Page-table memory: answers a held request two cycles after it appears
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_enable) begin
                if (donePtwFetch) begin
                    donePtwFetch = 1'b0;
                end else if (doPtwFetch) begin
                    wait_cnt++;
                    if (wait_cnt >= 2) begin
                        ptwData      = pte_mem.exists(ptwAddress) ? pte_mem[ptwAddress] : 64'h0;
                        donePtwFetch = 1'b1;
                        last_ptw     = ptwAddress;
                        walks++;
                        wait_cnt     = 0;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request and waits (bounded) for its result; action 1 = flush mid-walk, 2 = stray request
    task automatic fetch(input logic [63:0] va, input logic en, input logic [55:0] base,
                         input logic flush, input int action,
                         output logic ok, output logic [55:0] pa, output logic flt, output int cyc);
        doInstructionFetch = 1'b1;
        instructionAddress = va;
        translationEnable  = en;
        pageTableBase      = base;
        flushTlb           = flush;
        ok = 1'b0; pa = '0; flt = 1'b0; cyc = 0;
        while (!ok && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                doInstructionFetch = 1'b0;
                flushTlb           = 1'b0;
                translationEnable  = ~en;
                pageTableBase      = '1;
                if (action == 1) flushTlb = 1'b1;
                if (action == 2) begin
                    doInstructionFetch = 1'b1;
                    instructionAddress = 64'h7_7000;
                    translationEnable  = 1'b1;
                end
            end
            if (cyc == 2) begin
                doInstructionFetch = 1'b0;
                flushTlb           = 1'b0;
            end
            if (doneTranslation) begin
                ok  = 1'b1;
                pa  = translatedAddress;
                flt = translationFault;
            end
        end
        doInstructionFetch = 1'b0;
        flushTlb           = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({doneTranslation, translationFault, busy, doPtwFetch} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {doneTranslation, translationFault, busy, doPtwFetch}); end
        n_cmp++; if (translatedAddress !== 56'h0 || ptwAddress !== 56'h0) begin n_bad++; $display("FAIL reset_addr: got pa=%h ptw=%h want 0", translatedAddress, ptwAddress); end
        n_cmp++; if (tlbHitCount !== 32'd0 || tlbMissCount !== 32'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", tlbHitCount, tlbMissCount); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bare;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        w0 = walks;
        sb.push_back('{1'b0, 56'hFF_1234_5678_9ABC});
        fetch(64'h00FF_1234_5678_9ABC, 1'b0, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL bare_result: got ok=%0b flt=%0b pa=%h want flt=%0b pa=%h", ok, flt, pa, e.fault, e.pa); end
        n_cmp++; if (cyc !== 1 || walks !== w0) begin n_bad++; $display("FAIL bare_latency: got cyc=%0d walks=%0d want cyc=1 walks=%0d", cyc, walks, w0); end
    endtask

    task automatic test_translated;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        pte_mem[56'h8018] = 64'h0000_0000_00AB_C009;
        w0 = walks;
        sb.push_back('{1'b0, 56'hABC123});
        fetch(64'h3123, 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL walk_result: got ok=%0b flt=%0b pa=%h want flt=%0b pa=%h", ok, flt, pa, e.fault, e.pa); end
        n_cmp++; if (last_ptw !== 56'h8018 || walks !== w0 + 1) begin n_bad++; $display("FAIL walk_addr: got ptw=%h walks=%0d want ptw=8018 walks=%0d", last_ptw, walks, w0 + 1); end
        @(negedge clk);
        sb.push_back('{1'b0, 56'hABC456});
        fetch(64'h3456, 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL hit_result: got ok=%0b flt=%0b pa=%h want flt=%0b pa=%h", ok, flt, pa, e.fault, e.pa); end
        n_cmp++; if (cyc !== 1 || walks !== w0 + 1) begin n_bad++; $display("FAIL hit_latency: got cyc=%0d walks=%0d want cyc=1 walks=%0d", cyc, walks, w0 + 1); end
    endtask

    task automatic test_range_fault;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        w0 = walks;
        sb.push_back('{1'b1, 56'h0});
        fetch(64'h1_0000_3000, 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || flt !== e.fault || cyc !== 1 || walks !== w0) begin n_bad++; $display("FAIL range_fault: got ok=%0b flt=%0b cyc=%0d walks=%0d want flt=1 cyc=1 walks=%0d", ok, flt, cyc, walks, w0); end
    endtask

    task automatic test_bad_pte;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        pte_mem[56'h8028] = 64'h0000_0000_00AB_C008;
        pte_mem[56'h8030] = 64'h0000_0000_00AB_C001;
        w0 = walks;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b1, 56'h0});
            fetch((k == 2) ? 64'h6010 : 64'h5010, 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
            e = sb.pop_front();
            n_cmp++; if (!ok || flt !== e.fault) begin n_bad++; $display("FAIL bad_pte[%0d]: got ok=%0b flt=%0b want flt=1", k, ok, flt); end
            @(negedge clk);
        end
        n_cmp++; if (walks !== w0 + 3) begin n_bad++; $display("FAIL bad_pte_rewalk: got walks=%0d want %0d", walks, w0 + 3); end
    endtask

    task automatic test_eviction;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        flushTlb = 1'b1; @(negedge clk); flushTlb = 1'b0; @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            pte_mem[56'h8080 + 56'(p * 8)] = (64'(32'h100 + p) << 12) | 64'h9;
            sb.push_back('{1'b0, {44'(32'h100 + p), 12'h010}});
            fetch(64'h10010 + 64'(p * 32'h1000), 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
            e = sb.pop_front();
            n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL fill[%0d]: got ok=%0b flt=%0b pa=%h want pa=%h", p, ok, flt, pa, e.pa); end
            @(negedge clk);
        end
        w0 = walks;
        sb.push_back('{1'b0, 56'h101_020});
        fetch(64'h11020, 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || pa !== e.pa || walks !== w0) begin n_bad++; $display("FAIL evict_keep: got pa=%h walks=%0d want pa=%h walks=%0d", pa, walks, e.pa, w0); end
        @(negedge clk);
        sb.push_back('{1'b0, 56'h100_030});
        fetch(64'h10030, 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || pa !== e.pa || walks !== w0 + 1) begin n_bad++; $display("FAIL evict_victim: got pa=%h walks=%0d want pa=%h walks=%0d", pa, walks, e.pa, w0 + 1); end
        @(negedge clk);
    endtask

    task automatic test_flush_walk;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        pte_mem[56'h8100] = 64'h0000_0000_0055_5009;
        w0 = walks;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b0, 56'h555ABC});
            fetch(64'h20ABC, 1'b1, 56'h8000, 1'b0, (k == 0) ? 1 : 0, ok, pa, flt, cyc);
            e = sb.pop_front();
            n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL flush_walk[%0d]: got ok=%0b flt=%0b pa=%h want pa=%h", k, ok, flt, pa, e.pa); end
            @(negedge clk);
        end
        n_cmp++; if (walks !== w0 + 2) begin n_bad++; $display("FAIL flush_walk_count: got walks=%0d want %0d", walks, w0 + 2); end
    endtask

    task automatic test_flush_request;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; exp_t e;
        w0 = walks;
        sb.push_back('{1'b0, 56'h555123});
        fetch(64'h20123, 1'b1, 56'h8000, 1'b1, 0, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || pa !== e.pa || walks !== w0 + 1 || cyc < 2) begin n_bad++; $display("FAIL flush_request: got pa=%h walks=%0d cyc=%0d want pa=%h walks=%0d", pa, walks, cyc, e.pa, w0 + 1); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        logic ok; logic [55:0] pa; logic flt; int cyc; int w0; int extra; exp_t e;
        pte_mem[56'h8108] = 64'h0000_0000_0066_6009;
        w0 = walks;
        sb.push_back('{1'b0, 56'h666777});
        fetch(64'h21777, 1'b1, 56'h8000, 1'b0, 2, ok, pa, flt, cyc);
        e = sb.pop_front();
        n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL busy_result: got ok=%0b flt=%0b pa=%h want pa=%h", ok, flt, pa, e.pa); end
        extra = 0;
        repeat (6) begin @(negedge clk); if (doneTranslation) extra++; end
        n_cmp++; if (extra !== 0 || walks !== w0 + 1) begin n_bad++; $display("FAIL busy_ignore: got extra=%0d walks=%0d want 0 and %0d", extra, walks, w0 + 1); end
    endtask

    task automatic test_reset_midwalk;
        int n;
        resp_enable        = 1'b0;
        doInstructionFetch = 1'b1;
        instructionAddress = 64'h40000;
        translationEnable  = 1'b1;
        pageTableBase      = 56'h8000;
        @(negedge clk);
        doInstructionFetch = 1'b0;
        n = 0;
        while (!doPtwFetch && n < 10) begin @(negedge clk); n++; end
        n_cmp++; if (doPtwFetch !== 1'b1 || ptwAddress !== 56'h8200) begin n_bad++; $display("FAIL midwalk_req: got req=%b ptw=%h want 1 and 8200", doPtwFetch, ptwAddress); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (doPtwFetch !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midwalk_reset: got req=%b busy=%b want 0 0", doPtwFetch, busy); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); ptwData = 64'h0000_0000_00AB_C009; donePtwFetch = 1'b1;
        @(negedge clk); donePtwFetch = 1'b0;
        n_cmp++; if ({doneTranslation, busy, doPtwFetch} !== 3'b000) begin n_bad++; $display("FAIL late_ptw: got done/busy/req=%b want 000", {doneTranslation, busy, doPtwFetch}); end
        n_cmp++; if (tlbHitCount !== 32'd0 || tlbMissCount !== 32'd0) begin n_bad++; $display("FAIL midwalk_counters: got %0d/%0d want 0/0", tlbHitCount, tlbMissCount); end
        resp_enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_counters;
        logic ok; logic [55:0] pa; logic flt; int cyc; exp_t e;
        logic [63:0] vas [5];
        logic [55:0] pas [5];
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
        pte_mem[56'h8208] = 64'h0000_0000_0041_1009;
        pte_mem[56'h8210] = 64'h0000_0000_0042_2009;
        vas[0] = 64'h41000; vas[1] = 64'h42000; vas[2] = 64'h41ABC; vas[3] = 64'h42DEF; vas[4] = 64'h41001;
        pas[0] = 56'h411000; pas[1] = 56'h422000; pas[2] = 56'h411ABC; pas[3] = 56'h422DEF; pas[4] = 56'h411001;
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{1'b0, pas[k]});
            fetch(vas[k], 1'b1, 56'h8000, 1'b0, 0, ok, pa, flt, cyc);
            e = sb.pop_front();
            n_cmp++; if (!ok || flt !== e.fault || pa !== e.pa) begin n_bad++; $display("FAIL perf_seq[%0d]: got ok=%0b flt=%0b pa=%h want pa=%h", k, ok, flt, pa, e.pa); end
            @(negedge clk);
        end
`ifdef FETCH_MMU_PERF_EN
        exp_hit = 32'd3; exp_miss = 32'd2;
`else
        exp_hit = 32'd0; exp_miss = 32'd0;
`endif
        n_cmp++; if (tlbHitCount !== exp_hit || tlbMissCount !== exp_miss) begin n_bad++; $display("FAIL perf_counters: got %0d/%0d want %0d/%0d", tlbHitCount, tlbMissCount, exp_hit, exp_miss); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; walks = 0; last_ptw = '0;
        resp_enable        = 1'b1;
        reset              = 1'b0;
        doInstructionFetch = 1'b0;
        instructionAddress = '0;
        translationEnable  = 1'b0;
        pageTableBase      = '0;
        flushTlb           = 1'b0;
        ptwData            = '0;
        donePtwFetch       = 1'b0;
        test_reset();
        test_bare();
        test_translated();
        test_range_fault();
        test_bad_pte();
        test_eviction();
        test_flush_walk();
        test_flush_request();
        test_busy_ignore();
        test_reset_midwalk();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
